// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package hazard_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int REG_W_DEF  = 5;
    localparam int CNT_W      = 32;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALT   = 2'd1,
        REPLAY = 2'd2
    } state_e;

    // Saturating increment: holds at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard request / pipeline control bundle between the CPU datapath and the sequencer.
// Latency: n/a (wiring only).
// Backpressure: n/a; master drives hazard sources, slave drives latch controls.
interface pipeline_hazard_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5
);
    // hazard sources from the datapath
    logic              mem_stall_i;
    logic              redirect_i;
    logic [ADDR_W-1:0] target_i;
    logic [REG_W-1:0]  id_rs_i;
    logic [REG_W-1:0]  id_rt_i;
    logic [REG_W-1:0]  ex_rt_i;
    logic              ex_mem_read_i;

    // latch and PC controls back to the datapath
    logic              pc_write_o;
    logic              pc_redirect_o;
    logic [ADDR_W-1:0] redirect_pc_o;
    logic              if_id_write_o;
    logic              if_id_flush_o;
    logic              id_ex_bubble_o;
    logic              halt_o;

    modport master (
        output mem_stall_i, redirect_i, target_i, id_rs_i, id_rt_i, ex_rt_i, ex_mem_read_i,
        input  pc_write_o, pc_redirect_o, redirect_pc_o, if_id_write_o, if_id_flush_o,
               id_ex_bubble_o, halt_o
    );

    modport slave (
        input  mem_stall_i, redirect_i, target_i, id_rs_i, id_rt_i, ex_rt_i, ex_mem_read_i,
        output pc_write_o, pc_redirect_o, redirect_pc_o, if_id_write_o, if_id_flush_o,
               id_ex_bubble_o, halt_o
    );

endinterface

// File: rtl/hazard_perf_cnt.sv
// Single 32-bit saturating event counter.
// Latency: count reflects an event one edge after inc_i is seen.
// Backpressure: none; holds at all-ones once saturated.
module hazard_perf_cnt
    import hazard_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // next count: saturating bump on each event
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = sat_inc(cnt_q);
        end
    end

    // counter register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: cache halt > redirect > load-use; replays redirects caught in a halt.
// Latency: zero-cycle for halt/redirect/load-use; replayed redirect one cycle after the halt releases.
// Backpressure: mem_stall_i freezes all latches; optional perf counters under HAZARD_PERF_CNT_EN.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    pipeline_hazard_ctrl_if.slave  hz
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]       halt_cycles_o,
    output logic [CNT_W-1:0]       redirect_cnt_o,
    output logic [CNT_W-1:0]       loaduse_cnt_o
`endif
);

    state_e            state_q;
    state_e            state_d;
    logic              pend_q;
    logic              pend_d;
    logic [ADDR_W-1:0] tgt_q;
    logic [ADDR_W-1:0] tgt_d;

    logic [REG_W-1:0]  ex_rt;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic              load_use;

    logic              pc_write;
    logic              pc_redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic              if_id_write;
    logic              if_id_flush;
    logic              id_ex_bubble;

    assign ex_rt = hz.ex_rt_i;
    assign id_rs = hz.id_rs_i;
    assign id_rt = hz.id_rt_i;

    // load in EX writing a register the ID instruction reads; r0 never creates a hazard
    assign load_use = hz.ex_mem_read_i && (ex_rt != '0) &&
                      ((ex_rt == id_rs) || (ex_rt == id_rt));

    // next-state and combinational control decode
    always_comb begin
        state_d      = state_q;
        pend_d       = pend_q;
        tgt_d        = tgt_q;
        pc_write     = 1'b0;
        pc_redirect  = 1'b0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        // the replay target comes from the capture register only while replaying
        redirect_pc  = (state_q == REPLAY) ? tgt_q : hz.target_i;

        if (hz.mem_stall_i) begin
            // everything frozen; a redirect seen now is remembered, latest one wins
            if (hz.redirect_i) begin
                pend_d = 1'b1;
                tgt_d  = hz.target_i;
            end
            state_d = HALT;
        end else begin
            case (state_q)
                REPLAY: begin
                    // the captured redirect owns this cycle; flush supersedes any bubble
                    pc_write    = 1'b1;
                    pc_redirect = 1'b1;
                    if_id_write = 1'b1;
                    if_id_flush = 1'b1;
                    pend_d      = 1'b0;
                    state_d     = RUN;
                end
                default: begin
                    // RUN, and the HALT release cycle, which behaves exactly like RUN
                    if (hz.redirect_i) begin
                        pc_write    = 1'b1;
                        pc_redirect = 1'b1;
                        if_id_write = 1'b1;
                        if_id_flush = 1'b1;
                    end else if (load_use) begin
                        id_ex_bubble = 1'b1;
                    end else begin
                        pc_write    = 1'b1;
                        if_id_write = 1'b1;
                    end
                    state_d = ((state_q == HALT) && pend_q) ? REPLAY : RUN;
                end
            endcase
        end
    end

    // sequencer state, pending flag and captured target
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= RUN;
            pend_q  <= 1'b0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            tgt_q   <= tgt_d;
        end
    end

    assign hz.halt_o         = hz.mem_stall_i;
    assign hz.pc_write_o     = pc_write;
    assign hz.pc_redirect_o  = pc_redirect;
    assign hz.redirect_pc_o  = redirect_pc;
    assign hz.if_id_write_o  = if_id_write;
    assign hz.if_id_flush_o  = if_id_flush;
    assign hz.id_ex_bubble_o = id_ex_bubble;

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_cnt u_halt_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (hz.mem_stall_i),
        .cnt_o (halt_cycles_o)
    );

    hazard_perf_cnt u_redirect_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (pc_redirect),
        .cnt_o (redirect_cnt_o)
    );

    hazard_perf_cnt u_loaduse_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (id_ex_bubble),
        .cnt_o (loaduse_cnt_o)
    );
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: reset, load-use, redirects, halts and replays.
// Latency: inputs driven 1ns after the rising edge, outputs sampled on the falling edge.
// Backpressure: mem_stall_i patterns exercise halt capture and replay.
module tb_pipeline_hazard_ctrl;
    import hazard_pkg::*;

    // packed outputs {halt, pc_write, pc_redirect, if_id_write, if_id_flush, id_ex_bubble}
    localparam logic [5:0] O_NORM  = 6'b010100;
    localparam logic [5:0] O_HALT  = 6'b100000;
    localparam logic [5:0] O_REDIR = 6'b011110;
    localparam logic [5:0] O_BUB   = 6'b000001;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    int   tests = 0;
    int   fails = 0;

    pipeline_hazard_ctrl_if #(.ADDR_W(32), .REG_W(5)) bus ();

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] halt_cycles;
    logic [CNT_W-1:0] redirect_cnt;
    logic [CNT_W-1:0] loaduse_cnt;
`endif

    pipeline_hazard_ctrl #(.ADDR_W(32), .REG_W(5)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .hz    (bus)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .halt_cycles_o  (halt_cycles),
        .redirect_cnt_o (redirect_cnt),
        .loaduse_cnt_o  (loaduse_cnt)
`endif
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [5:0] outs();
        return {bus.halt_o, bus.pc_write_o, bus.pc_redirect_o,
                bus.if_id_write_o, bus.if_id_flush_o, bus.id_ex_bubble_o};
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        bus.mem_stall_i   = 1'b0;
        bus.redirect_i    = 1'b0;
        bus.target_i      = '0;
        bus.id_rs_i       = '0;
        bus.id_rt_i       = '0;
        bus.ex_rt_i       = '0;
        bus.ex_mem_read_i = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst_i = 1'b0;
        @(negedge clk_i);
        tests++;
        if (outs() !== O_NORM) begin
            fails++;
            $display("FAIL reset_outs got %b expected %b", outs(), O_NORM);
        end
        tests++;
        if (bus.redirect_pc_o !== 32'h0) begin
            fails++;
            $display("FAIL reset_pc got %h expected %h", bus.redirect_pc_o, 32'h0);
        end
        step();
        rst_i = 1'b1;
        step();
    endtask

    task automatic test_load_use();
        // rs match: one bubble
        bus.ex_mem_read_i = 1'b1; bus.ex_rt_i = 5'd5; bus.id_rs_i = 5'd5; bus.id_rt_i = 5'd7;
        @(negedge clk_i);
        tests++;
        if (outs() !== O_BUB) begin
            fails++;
            $display("FAIL loaduse_rs got %b expected %b", outs(), O_BUB);
        end
        step();
        // EX now holds the bubble: hazard gone
        idle(); bus.id_rs_i = 5'd5;
        @(negedge clk_i);
        tests++;
        if (outs() !== O_NORM) begin
            fails++;
            $display("FAIL loaduse_after got %b expected %b", outs(), O_NORM);
        end
        step();
        // rt match
        bus.ex_mem_read_i = 1'b1; bus.ex_rt_i = 5'd9; bus.id_rs_i = 5'd1; bus.id_rt_i = 5'd9;
        @(negedge clk_i);
        tests++;
        if (outs() !== O_BUB) begin
            fails++;
            $display("FAIL loaduse_rt got %b expected %b", outs(), O_BUB);
        end
        step();
        // r0 never hazards
        bus.ex_mem_read_i = 1'b1; bus.ex_rt_i = 5'd0; bus.id_rs_i = 5'd0; bus.id_rt_i = 5'd0;
        @(negedge clk_i);
        tests++;
        if (outs() !== O_NORM) begin
            fails++;
            $display("FAIL loaduse_r0 got %b expected %b", outs(), O_NORM);
        end
        step();
        // match but not a load
        bus.ex_mem_read_i = 1'b0; bus.ex_rt_i = 5'd5; bus.id_rs_i = 5'd5;
        @(negedge clk_i);
        tests++;
        if (outs() !== O_NORM) begin
            fails++;
            $display("FAIL loaduse_noload got %b expected %b", outs(), O_NORM);
        end
        step();
        idle();
    endtask

    task automatic test_live_redirect();
        bus.redirect_i = 1'b1; bus.target_i = 32'h40;
        @(negedge clk_i);
        tests++;
        if (outs() !== O_REDIR || bus.redirect_pc_o !== 32'h40) begin
            fails++;
            $display("FAIL live_redirect got %b/%h expected %b/%h",
                     outs(), bus.redirect_pc_o, O_REDIR, 32'h40);
        end
        step();
        idle();
        @(negedge clk_i);
        tests++;
        if (outs() !== O_NORM) begin
            fails++;
            $display("FAIL live_redirect_after got %b expected %b", outs(), O_NORM);
        end
        step();
    endtask

    task automatic test_redirect_during_miss();
        for (int c = 0; c < 10; c++) begin
            bus.mem_stall_i = 1'b1;
            bus.redirect_i  = (c == 3);
            bus.target_i    = (c == 3) ? 32'h80 : ((c == 6) ? 32'h999 : 32'h0);
            @(negedge clk_i);
            tests++;
            if (outs() !== O_HALT) begin
                fails++;
                $display("FAIL miss_halt c=%0d got %b expected %b", c, outs(), O_HALT);
            end
            step();
        end
        idle();
        // release cycle: plain RUN behaviour
        @(negedge clk_i);
        tests++;
        if (outs() !== O_NORM) begin
            fails++;
            $display("FAIL miss_release got %b expected %b", outs(), O_NORM);
        end
        step();
        // replay one cycle after the stall fell
        @(negedge clk_i);
        tests++;
        if (outs() !== O_REDIR || bus.redirect_pc_o !== 32'h80) begin
            fails++;
            $display("FAIL miss_replay got %b/%h expected %b/%h",
                     outs(), bus.redirect_pc_o, O_REDIR, 32'h80);
        end
        step();
        @(negedge clk_i);
        tests++;
        if (outs() !== O_NORM || bus.redirect_pc_o !== 32'h0) begin
            fails++;
            $display("FAIL miss_back_run got %b/%h expected %b/%h",
                     outs(), bus.redirect_pc_o, O_NORM, 32'h0);
        end
        step();
    endtask

    task automatic test_back_to_back();
        // two pulses in one halt: the later target wins
        bus.mem_stall_i = 1'b1; bus.redirect_i = 1'b1; bus.target_i = 32'h100;
        step();
        bus.target_i = 32'h104;
        step();
        bus.redirect_i = 1'b0; bus.target_i = '0;
        step();
        idle();
        step();                              // release cycle -> REPLAY
        bus.mem_stall_i = 1'b1;              // stall re-asserts in the replay cycle
        @(negedge clk_i);
        tests++;
        if (outs() !== O_HALT) begin
            fails++;
            $display("FAIL b2b_halt_wins got %b expected %b", outs(), O_HALT);
        end
        step();
        step();
        idle();
        @(negedge clk_i);
        tests++;
        if (outs() !== O_NORM) begin
            fails++;
            $display("FAIL b2b_release got %b expected %b", outs(), O_NORM);
        end
        step();
        @(negedge clk_i);
        tests++;
        if (outs() !== O_REDIR || bus.redirect_pc_o !== 32'h104) begin
            fails++;
            $display("FAIL b2b_replay got %b/%h expected %b/%h",
                     outs(), bus.redirect_pc_o, O_REDIR, 32'h104);
        end
        step();
    endtask

    task automatic test_redirect_vs_loaduse();
        bus.redirect_i = 1'b1; bus.target_i = 32'h200;
        bus.ex_mem_read_i = 1'b1; bus.ex_rt_i = 5'd3; bus.id_rt_i = 5'd3;
        @(negedge clk_i);
        tests++;
        if (outs() !== O_REDIR || bus.redirect_pc_o !== 32'h200) begin
            fails++;
            $display("FAIL redir_vs_lu got %b/%h expected %b/%h",
                     outs(), bus.redirect_pc_o, O_REDIR, 32'h200);
        end
        step();
        idle();
    endtask

    task automatic test_release_loaduse();
        bus.mem_stall_i = 1'b1;
        step();
        step();
        bus.mem_stall_i = 1'b0;
        bus.ex_mem_read_i = 1'b1; bus.ex_rt_i = 5'd12; bus.id_rs_i = 5'd12;
        @(negedge clk_i);
        tests++;
        if (outs() !== O_BUB) begin
            fails++;
            $display("FAIL release_lu got %b expected %b", outs(), O_BUB);
        end
        step();
        idle();
        @(negedge clk_i);
        tests++;
        if (outs() !== O_NORM) begin
            fails++;
            $display("FAIL release_lu_after got %b expected %b", outs(), O_NORM);
        end
        step();
    endtask

    task automatic test_reset_mid_halt();
        bus.mem_stall_i = 1'b1; bus.redirect_i = 1'b1; bus.target_i = 32'h55;
        step();
        bus.redirect_i = 1'b0; bus.target_i = '0;
        rst_i = 1'b0;                        // asynchronous, mid-cycle
        @(negedge clk_i);
        tests++;
        if (outs() !== O_HALT) begin
            fails++;
            $display("FAIL rst_halt got %b expected %b", outs(), O_HALT);
        end
        step();
        idle();
`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk_i);
        tests++;
        if (halt_cycles !== 32'd0 || redirect_cnt !== 32'd0 || loaduse_cnt !== 32'd0) begin
            fails++;
            $display("FAIL rst_counters got %0d/%0d/%0d expected 0/0/0",
                     halt_cycles, redirect_cnt, loaduse_cnt);
        end
`endif
        step();
        rst_i = 1'b1;
        @(negedge clk_i);
        tests++;
        if (outs() !== O_NORM) begin
            fails++;
            $display("FAIL rst_release got %b expected %b", outs(), O_NORM);
        end
        step();
        @(negedge clk_i);
        tests++;
        if (outs() !== O_NORM || bus.redirect_pc_o !== 32'h0) begin
            fails++;
            $display("FAIL rst_no_replay got %b/%h expected %b/%h",
                     outs(), bus.redirect_pc_o, O_NORM, 32'h0);
        end
        step();
    endtask

`ifdef HAZARD_PERF_CNT_EN
    task automatic test_perf_cnt();
        // two halt cycles with a captured redirect, release, replay, live redirect, one bubble
        bus.mem_stall_i = 1'b1; bus.redirect_i = 1'b1; bus.target_i = 32'h10;
        step();
        bus.redirect_i = 1'b0; bus.target_i = '0;
        step();
        idle();
        step();                              // release
        step();                              // replay
        bus.redirect_i = 1'b1; bus.target_i = 32'h20;
        step();
        idle();
        bus.ex_mem_read_i = 1'b1; bus.ex_rt_i = 5'd4; bus.id_rs_i = 5'd4;
        step();
        idle();
        @(negedge clk_i);
        tests++;
        if (halt_cycles !== 32'd2 || redirect_cnt !== 32'd2 || loaduse_cnt !== 32'd1) begin
            fails++;
            $display("FAIL perf_counts got %0d/%0d/%0d expected 2/2/1",
                     halt_cycles, redirect_cnt, loaduse_cnt);
        end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_live_redirect();
        test_redirect_during_miss();
        test_back_to_back();
        test_redirect_vs_loaduse();
        test_release_loaduse();
        test_reset_mid_halt();
`ifdef HAZARD_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
